battle_phase_ctrl: RTL and testbench
====================================

BATTLE_PHASE_CTRL -- requirements
Module: battle_phase_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_HP, default 20, giving the starting player HP (1..255).
REQ-002 The block SHALL have parameter NUM_TURNS, default 8, giving the enemy turns to survive (1..15).
REQ-003 The block SHALL have parameter IFRAME_CYCLES, default 32_500_000, giving post-hit invulnerability cycles.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 650_000_000, giving the enemy-phase watchdog limit.
REQ-005 Port clk, input, 1 bit: the single system clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port start_in, input, 1 bit: one-cycle request to begin a battle from IDLE.
REQ-008 Port action_in, input, 1 bit: one-cycle player-menu confirm ending the player turn.
REQ-009 Port enemy_busy_in, input, 1 bit: enemy attack phase in progress.
REQ-010 Port enemy_finished_in, input, 1 bit: one-cycle pulse at the end of the enemy attack.
REQ-011 Port damage_in, input, 1 bit: arrow-hit indication from the enemy.
REQ-012 Port state_out, output, 4 bits: phase code driven to the enemy and renderers.
REQ-013 Port turn_out, output, 4 bits: current turn index used for pattern selection.
REQ-014 Port hp_out, output, 8 bits: current player HP.
REQ-015 Port hit_flash_out, output, 1 bit: high while invulnerability is active.
REQ-016 Port win_out and port lose_out, outputs, 1 bit each: battle result levels.

Function
REQ-017 State encodings SHALL be IDLE=4'b0000, MENU=4'b0001, LOSE=4'b0010, WIN=4'b0100 and ENEMY=4'b1000, and state_out SHALL equal the registered state.
REQ-018 In IDLE, start_in SHALL load hp_out=MAX_HP and turn_out=0 and move to MENU on the next cycle.
REQ-019 In MENU, action_in SHALL move to ENEMY and clear the watchdog counter; state_out therefore changes to 4'b1000 for exactly one edge-detect event.
REQ-020 In ENEMY, a cycle with enemy_finished_in=1 and hp_out>0 after damage SHALL increment turn_out and go to WIN if the new turn_out==NUM_TURNS, else to MENU.
REQ-021 Damage SHALL be detected on the rising edge of damage_in, using one registered copy.
REQ-022 A rising edge while ENEMY and not invulnerable SHALL decrement hp_out by 1, saturating at 0, and load the invulnerability counter with IFRAME_CYCLES.
REQ-023 Rising edges during invulnerability, or outside ENEMY, SHALL be ignored.
REQ-024 hit_flash_out SHALL equal (invulnerability counter != 0), and the counter SHALL decrement each cycle to 0.
REQ-025 If hp_out reaches 0, the block SHALL enter LOSE on the next cycle, with priority over a simultaneous enemy_finished_in.
REQ-026 If the watchdog reaches TIMEOUT_CYCLES in ENEMY, the block SHALL treat this as finished and apply the REQ-020 transition.
REQ-027 The watchdog SHALL be 32 bits wide.
REQ-028 enemy_busy_in SHALL be informational only and SHALL NOT gate transitions.
REQ-029 WIN and LOSE SHALL be held, with win_out and lose_out asserted, until start_in, which behaves as in REQ-018.
REQ-030 start_in SHALL be ignored in MENU and ENEMY.
REQ-031 action_in SHALL be ignored outside MENU.
REQ-032 turn_out SHALL never exceed NUM_TURNS.

Reset
REQ-033 Assertion of rst_n=0 SHALL asynchronously force state IDLE, turn_out=0, hp_out=MAX_HP, and clear the invulnerability counter, watchdog, damage edge register, win_out and lose_out.
REQ-034 Reset mid-ENEMY SHALL abort the phase, with no turn increment on release.
REQ-035 The first clock edge after rst_n rises SHALL evaluate normally.

Structure
REQ-036 The phase encodings SHALL be a typedef enum logic[3:0] in the shared package battle_pkg, which the enemy and renderers also import.
REQ-037 The watchdog and invulnerability counter SHALL be a single reusable sub-module, down_timer, with load, value and zero flag.
REQ-038 All other logic SHALL be one always_ff block and one always_comb block.

Verification
REQ-039 Scenario: start, then action -> state_out goes 0000->0001->1000; finished pulse -> turn_out=1, state_out=0001.
REQ-040 Scenario: damage rising edges at t and t+10 with IFRAME_CYCLES=100 -> hp_out 20->19 only, and hit_flash_out is high for 100 cycles.
REQ-041 Scenario: MAX_HP=1 and a damage edge coincident with enemy_finished_in -> LOSE, lose_out=1, turn_out unchanged.
REQ-042 Scenario: NUM_TURNS=2 with two clean enemy phases -> WIN, win_out=1, turn_out=2; then start -> MENU, hp_out=MAX_HP.
REQ-043 Scenario: TIMEOUT_CYCLES=50 with no finished pulse -> the transition to MENU occurs at cycle 50 of ENEMY.
REQ-044 Scenario: rst_n low mid-ENEMY between clock edges -> state_out=0000 immediately, hp_out=MAX_HP.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared phase encodings and helpers for the battle controller, enemy and renderers.
// Latency: none; types and pure functions only.
// Backpressure: none; nothing in this package holds state or handshakes.
package battle_pkg;

    typedef enum logic [3:0] {
        PH_IDLE  = 4'b0000,
        PH_MENU  = 4'b0001,
        PH_LOSE  = 4'b0010,
        PH_WIN   = 4'b0100,
        PH_ENEMY = 4'b1000
    } phase_e;

    // Width of both the watchdog and the invulnerability timer.
    localparam int unsigned WD_W = 32;

    // One point of damage, never wrapping below zero.
    function automatic logic [7:0] hp_sat_dec(input logic [7:0] hp);
        return (hp == 8'd0) ? 8'd0 : hp - 8'd1;
    endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter that stops at zero; used for the watchdog and the invulnerability window.
// Latency: load_i takes effect on the next edge; the count then drops by one per cycle.
// Backpressure: none; load_i always wins over counting.
module down_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] value_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/battle_phase_ctrl.sv
// Battle phase sequencer: menu / enemy attack turns, player HP, hit invulnerability, win/lose.
// Latency: every input acts on the next clock edge; outputs are registered state.
// Backpressure: none; single-cycle pulses are consumed only in the phase that honours them.
module battle_phase_ctrl
    import battle_pkg::*;
#(
    parameter int unsigned MAX_HP         = 20,
    parameter int unsigned NUM_TURNS      = 8,
    parameter int unsigned IFRAME_CYCLES  = 32_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 650_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_in,
    input  logic       action_in,
    input  logic       enemy_busy_in,
    input  logic       enemy_finished_in,
    input  logic       damage_in,
    output logic [3:0] state_out,
    output logic [3:0] turn_out,
    output logic [7:0] hp_out,
    output logic       hit_flash_out,
    output logic       win_out,
    output logic       lose_out
);

    localparam logic [7:0]      HP_INIT   = 8'(MAX_HP);
    localparam logic [3:0]      TURN_LAST = 4'(NUM_TURNS);
    localparam logic [WD_W-1:0] IF_LOAD   = IFRAME_CYCLES;
    // Loaded one short so the enemy phase lasts exactly TIMEOUT_CYCLES cycles
    // before the watchdog forces the end-of-turn transition.
    localparam logic [WD_W-1:0] WD_LOAD   = TIMEOUT_CYCLES - 1;

    phase_e          state_q, state_d;
    logic [7:0]      hp_q, hp_d;
    logic [3:0]      turn_q, turn_d;
    logic            dmg_q;

    logic            dmg_rise;
    logic            hit;
    logic [7:0]      hp_after;
    logic [3:0]      turn_inc;
    logic            ifr_load;
    logic            wd_load;
    logic [WD_W-1:0] ifr_val;
    logic            ifr_zero;
    logic [WD_W-1:0] wd_val_unused;
    logic            wd_zero;
    logic            busy_unused;

    down_timer #(.WIDTH(WD_W)) u_iframe (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ifr_load),
        .load_val_i (IF_LOAD),
        .value_o    (ifr_val),
        .zero_o     (ifr_zero)
    );

    down_timer #(.WIDTH(WD_W)) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (wd_load),
        .load_val_i (WD_LOAD),
        .value_o    (wd_val_unused),
        .zero_o     (wd_zero)
    );

    // Phase transitions, damage handling and output decode.
    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        turn_d   = turn_q;
        wd_load  = 1'b0;

        // Only a fresh hit during the enemy phase outside the invulnerability window counts.
        dmg_rise = damage_in & ~dmg_q;
        hit      = (state_q == PH_ENEMY) && dmg_rise && ifr_zero;
        ifr_load = hit;
        hp_after = hit ? hp_sat_dec(hp_q) : hp_q;
        turn_inc = turn_q + 4'd1;

        case (state_q)
            PH_IDLE, PH_WIN, PH_LOSE: begin
                if (start_in) begin
                    hp_d    = HP_INIT;
                    turn_d  = 4'd0;
                    state_d = PH_MENU;
                end
            end
            PH_MENU: begin
                if (action_in) begin
                    state_d = PH_ENEMY;
                    wd_load = 1'b1;
                end
            end
            PH_ENEMY: begin
                hp_d = hp_after;
                // Death beats a simultaneous end of the attack.
                if (hp_after == 8'd0) begin
                    state_d = PH_LOSE;
                end else if (enemy_finished_in || wd_zero) begin
                    turn_d  = turn_inc;
                    state_d = (turn_inc == TURN_LAST) ? PH_WIN : PH_MENU;
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase

        state_out     = state_q;
        turn_out      = turn_q;
        hp_out        = hp_q;
        hit_flash_out = (ifr_val != '0);
        win_out       = (state_q == PH_WIN);
        lose_out      = (state_q == PH_LOSE);
        // The enemy's busy flag is status only; no transition waits on it.
        busy_unused   = enemy_busy_in;
    end

    // Phase, HP, turn and damage-edge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PH_IDLE;
            hp_q    <= HP_INIT;
            turn_q  <= 4'd0;
            dmg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            turn_q  <= turn_d;
            dmg_q   <= damage_in;
        end
    end

endmodule

// File: tb/tb_battle_phase_ctrl.sv
// Bench for battle_phase_ctrl: two differently parameterised instances share one stimulus.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; inputs are driven as single-cycle pulses or levels.
module tb_battle_phase_ctrl;

    localparam int A_HP = 20, A_NT = 2, A_IF = 100, A_TO = 50;
    localparam int B_HP = 1,  B_NT = 3, B_IF = 10,  B_TO = 40;

    localparam int C_IDLE = 0, C_MENU = 1, C_LOSE = 2, C_WIN = 4, C_ENEMY = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_in, action_in, enemy_busy_in, enemy_finished_in, damage_in;
    logic [3:0] st_a, tn_a, st_b, tn_b;
    logic [7:0] hp_a, hp_b;
    logic fl_a, win_a, lose_a, fl_b, win_b, lose_b;

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int p_hp[2], p_nt[2], p_if[2], p_to[2];
    int m_ph[2], m_hp[2], m_turn[2], m_ifr[2], m_el[2];
    bit m_dprev[2];

    battle_phase_ctrl #(.MAX_HP(A_HP), .NUM_TURNS(A_NT), .IFRAME_CYCLES(A_IF), .TIMEOUT_CYCLES(A_TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .action_in(action_in),
        .enemy_busy_in(enemy_busy_in), .enemy_finished_in(enemy_finished_in), .damage_in(damage_in),
        .state_out(st_a), .turn_out(tn_a), .hp_out(hp_a), .hit_flash_out(fl_a),
        .win_out(win_a), .lose_out(lose_a)
    );

    battle_phase_ctrl #(.MAX_HP(B_HP), .NUM_TURNS(B_NT), .IFRAME_CYCLES(B_IF), .TIMEOUT_CYCLES(B_TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .action_in(action_in),
        .enemy_busy_in(enemy_busy_in), .enemy_finished_in(enemy_finished_in), .damage_in(damage_in),
        .state_out(st_b), .turn_out(tn_b), .hp_out(hp_b), .hit_flash_out(fl_b),
        .win_out(win_b), .lose_out(lose_b)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = C_IDLE; m_hp[k] = p_hp[k]; m_turn[k] = 0;
            m_ifr[k] = 0; m_el[k] = 0; m_dprev[k] = 1'b0;
        end
    endtask

    // One clock of game rules, applied to the inputs present at the edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit rise;
            bit hit;
            rise = damage_in && !m_dprev[k];
            m_dprev[k] = damage_in;
            hit = 1'b0;
            if (m_ph[k] == C_IDLE || m_ph[k] == C_WIN || m_ph[k] == C_LOSE) begin
                if (start_in) begin
                    m_hp[k] = p_hp[k]; m_turn[k] = 0; m_ph[k] = C_MENU;
                end
            end else if (m_ph[k] == C_MENU) begin
                if (action_in) begin
                    m_ph[k] = C_ENEMY; m_el[k] = 0;
                end
            end else begin
                m_el[k] = m_el[k] + 1;
                hit = rise && (m_ifr[k] == 0);
                if (hit && m_hp[k] > 0) m_hp[k] = m_hp[k] - 1;
                if (m_hp[k] == 0) begin
                    m_ph[k] = C_LOSE;
                end else if (enemy_finished_in || m_el[k] == p_to[k]) begin
                    m_turn[k] = m_turn[k] + 1;
                    m_ph[k] = (m_turn[k] == p_nt[k]) ? C_WIN : C_MENU;
                end
            end
            if (hit) m_ifr[k] = p_if[k];
            else if (m_ifr[k] > 0) m_ifr[k] = m_ifr[k] - 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        start_in = 0; action_in = 0; enemy_busy_in = 0; enemy_finished_in = 0; damage_in = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();  start_in = 1;          cycle(); start_in = 0;          endtask
    task automatic pulse_action(); action_in = 1;         cycle(); action_in = 0;         endtask
    task automatic pulse_fin();    enemy_finished_in = 1; cycle(); enemy_finished_in = 0; endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (st_a !== 4'b0000) begin fails++; $display("FAIL reset_state got %b exp 0000", st_a); end
        tests++; if (hp_a !== 8'd20)   begin fails++; $display("FAIL reset_hp_a got %0d exp 20", hp_a); end
        tests++; if (hp_b !== 8'd1)    begin fails++; $display("FAIL reset_hp_b got %0d exp 1", hp_b); end
        tests++; if (tn_a !== 4'd0)    begin fails++; $display("FAIL reset_turn got %0d exp 0", tn_a); end
        tests++; if ({fl_a, win_a, lose_a} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {fl_a, win_a, lose_a}); end
    endtask

    task automatic test_menu_flow();
        apply_reset();
        pulse_start();
        tests++; if (st_a !== 4'b0001) begin fails++; $display("FAIL flow_menu got %b exp 0001", st_a); end
        pulse_action();
        tests++; if (st_a !== 4'b1000) begin fails++; $display("FAIL flow_enemy got %b exp 1000", st_a); end
        pulse_fin();
        tests++; if (st_a !== 4'b0001 || tn_a !== 4'd1) begin fails++; $display("FAIL flow_turn got st=%b turn=%0d exp st=0001 turn=1", st_a, tn_a); end
        pulse_start();
        tests++; if (st_a !== 4'b0001 || tn_a !== 4'd1) begin fails++; $display("FAIL start_in_menu got st=%b turn=%0d exp st=0001 turn=1", st_a, tn_a); end
    endtask

    task automatic test_iframe();
        int flash_cnt;
        apply_reset();
        pulse_start();
        pulse_action();
        damage_in = 1;
        cycle();
        tests++; if (hp_a !== 8'd19) begin fails++; $display("FAIL iframe_first_hit got %0d exp 19", hp_a); end
        flash_cnt = fl_a ? 1 : 0;
        for (int i = 1; i <= 150; i++) begin
            damage_in = (i == 10);
            cycle();
            if (fl_a) flash_cnt++;
        end
        tests++; if (hp_a !== 8'd19) begin fails++; $display("FAIL iframe_second_hit got %0d exp 19", hp_a); end
        tests++; if (flash_cnt != A_IF) begin fails++; $display("FAIL iframe_flash_len got %0d exp %0d", flash_cnt, A_IF); end
        tests++; if (lose_b !== 1'b1 || st_b !== 4'b0010) begin fails++; $display("FAIL iframe_b_lose got st=%b lose=%b exp 0010/1", st_b, lose_b); end
        damage_in = 1;
        cycle();
        damage_in = 0;
        tests++; if (hp_a !== 8'd19) begin fails++; $display("FAIL damage_outside_enemy got %0d exp 19", hp_a); end
    endtask

    task automatic test_lose_priority();
        apply_reset();
        pulse_start();
        pulse_action();
        damage_in = 1; enemy_finished_in = 1;
        cycle();
        damage_in = 0; enemy_finished_in = 0;
        tests++; if (st_b !== 4'b0010 || lose_b !== 1'b1) begin fails++; $display("FAIL lose_prio got st=%b lose=%b exp 0010/1", st_b, lose_b); end
        tests++; if (tn_b !== 4'd0 || hp_b !== 8'd0) begin fails++; $display("FAIL lose_turn_hp got turn=%0d hp=%0d exp 0/0", tn_b, hp_b); end
        tests++; if (st_a !== 4'b0001 || tn_a !== 4'd1 || hp_a !== 8'd19) begin fails++; $display("FAIL lose_a_side got st=%b turn=%0d hp=%0d exp 0001/1/19", st_a, tn_a, hp_a); end
        repeat (5) cycle();
        tests++; if (st_b !== 4'b0010) begin fails++; $display("FAIL lose_hold got %b exp 0010", st_b); end
        pulse_start();
        tests++; if (st_b !== 4'b0001 || hp_b !== 8'd1 || lose_b !== 1'b0) begin fails++; $display("FAIL lose_restart got st=%b hp=%0d exp 0001/1", st_b, hp_b); end
    endtask

    task automatic test_win();
        apply_reset();
        pulse_start();
        repeat (2) begin
            pulse_action();
            pulse_fin();
        end
        tests++; if (st_a !== 4'b0100 || win_a !== 1'b1 || tn_a !== 4'd2) begin fails++; $display("FAIL win got st=%b win=%b turn=%0d exp 0100/1/2", st_a, win_a, tn_a); end
        pulse_action();
        repeat (4) cycle();
        tests++; if (st_a !== 4'b0100 || tn_a !== 4'd2) begin fails++; $display("FAIL win_hold got st=%b turn=%0d exp 0100/2", st_a, tn_a); end
        pulse_start();
        tests++; if (st_a !== 4'b0001 || hp_a !== 8'd20 || tn_a !== 4'd0 || win_a !== 1'b0) begin fails++; $display("FAIL win_restart got st=%b hp=%0d turn=%0d exp 0001/20/0", st_a, hp_a, tn_a); end
    endtask

    task automatic test_timeout();
        int cnt;
        apply_reset();
        pulse_start();
        enemy_busy_in = 1;
        pulse_action();
        cnt = (st_a == 4'b1000) ? 1 : 0;
        while (st_a == 4'b1000 && cnt < 200) begin
            cycle();
            if (st_a == 4'b1000) cnt++;
        end
        enemy_busy_in = 0;
        tests++; if (cnt != A_TO) begin fails++; $display("FAIL timeout_len got %0d exp %0d", cnt, A_TO); end
        tests++; if (st_a !== 4'b0001 || tn_a !== 4'd1) begin fails++; $display("FAIL timeout_next got st=%b turn=%0d exp 0001/1", st_a, tn_a); end
        tests++; if (st_b !== 4'b0001 || tn_b !== 4'd1) begin fails++; $display("FAIL timeout_b got st=%b turn=%0d exp 0001/1", st_b, tn_b); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pulse_start();
        pulse_action();
        damage_in = 1;
        cycle();
        damage_in = 0;
        repeat (3) cycle();
        tests++; if (st_a !== 4'b1000 || hp_a !== 8'd19) begin fails++; $display("FAIL pre_reset got st=%b hp=%0d exp 1000/19", st_a, hp_a); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++; if (st_a !== 4'b0000 || hp_a !== 8'd20 || fl_a !== 1'b0) begin fails++; $display("FAIL async_reset got st=%b hp=%0d flash=%b exp 0000/20/0", st_a, hp_a, fl_a); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        tests++; if (st_a !== 4'b0000 || tn_a !== 4'd0) begin fails++; $display("FAIL reset_release got st=%b turn=%0d exp 0000/0", st_a, tn_a); end
        pulse_start();
        tests++; if (st_a !== 4'b0001) begin fails++; $display("FAIL first_edge_after_reset got %b exp 0001", st_a); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            start_in          = ($urandom % 16) == 0;
            action_in         = ($urandom % 6) == 0;
            enemy_finished_in = ($urandom % 20) == 0;
            enemy_busy_in     = $urandom % 2;
            if (($urandom % 5) == 0) damage_in = ~damage_in;
            cycle();
            for (int k = 0; k < 2; k++) begin
                logic [3:0] st, tn;
                logic [7:0] hp;
                logic fl, w, l;
                st = k ? st_b : st_a; tn = k ? tn_b : tn_a; hp = k ? hp_b : hp_a;
                fl = k ? fl_b : fl_a; w = k ? win_b : win_a; l = k ? lose_b : lose_a;
                tests++; if (st !== 4'(m_ph[k])) begin fails++; $display("FAIL rnd_state dut%0d cyc %0d got %b exp %b", k, c, st, 4'(m_ph[k])); end
                tests++; if (tn !== 4'(m_turn[k])) begin fails++; $display("FAIL rnd_turn dut%0d cyc %0d got %0d exp %0d", k, c, tn, m_turn[k]); end
                tests++; if (hp !== 8'(m_hp[k])) begin fails++; $display("FAIL rnd_hp dut%0d cyc %0d got %0d exp %0d", k, c, hp, m_hp[k]); end
                tests++; if (fl !== (m_ifr[k] != 0)) begin fails++; $display("FAIL rnd_flash dut%0d cyc %0d got %b exp %b", k, c, fl, m_ifr[k] != 0); end
                tests++; if (w !== (m_ph[k] == C_WIN) || l !== (m_ph[k] == C_LOSE)) begin fails++; $display("FAIL rnd_result dut%0d cyc %0d got win=%b lose=%b", k, c, w, l); end
            end
        end
        start_in = 0; action_in = 0; enemy_finished_in = 0; enemy_busy_in = 0; damage_in = 0;
    endtask

    initial begin
        p_hp[0] = A_HP; p_nt[0] = A_NT; p_if[0] = A_IF; p_to[0] = A_TO;
        p_hp[1] = B_HP; p_nt[1] = B_NT; p_if[1] = B_IF; p_to[1] = B_TO;
        rst_n = 1'b0;
        test_reset();
        test_menu_flow();
        test_iframe();
        test_lose_priority();
        test_win();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
